// File: rtl/audio_pkg.sv
// Shared constants for the audio output path: default sample width and divider ratio,
// plus the PWM period helper (2^SAMPLE_W - 1).
package audio_pkg;

    localparam int SAMPLE_W_DEF = 4;
    localparam int CLK_DIV_DEF  = 1536;
    localparam int DIV_W        = 16;

    // One PWM period spans 2^w - 1 cycles so that full scale maps to "always high".
    function automatic int pwm_period(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int PWM_PERIOD = pwm_period(SAMPLE_W_DEF);

endpackage

// File: rtl/audio_tick.sv
// Sample-rate divider: counts 0..CLK_DIV-1 and raises a one-cycle strobe in the last count.
// Shared by any audio block that needs the sample-period timebase.
module audio_tick
    import audio_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic             clock,
    input  logic             reset,
    output logic             sample_ena,
    output logic [DIV_W-1:0] div_cnt
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;

    always_comb begin
        div_cnt_next = div_cnt_reg + DIV_W'(1);
        if (div_cnt_reg == DIV_LAST) begin
            div_cnt_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    // Decoded straight from the counter, so a reset leaves no partial strobe behind.
    assign sample_ena = (div_cnt_reg == DIV_LAST);
    assign div_cnt    = div_cnt_reg;

endmodule

// File: rtl/audio_dac_out.sv
// 1-bit audio DAC back end: captures the mixed sample once per sample period and modulates it.
// Default is PWM; define AUDIO_SDM_EN to use a first-order sigma-delta modulator instead.
module audio_dac_out
    import audio_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                mute,
    output logic                sample_ena,
    output logic                audio_out,
    output logic [SAMPLE_W-1:0] active_sample
);

    localparam logic [SAMPLE_W-1:0] PWM_LAST = SAMPLE_W'(pwm_period(SAMPLE_W) - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [SAMPLE_W-1:0] pwm_cnt_reg;
    logic [SAMPLE_W-1:0] pwm_cnt_next;
    logic [SAMPLE_W-1:0] pending_reg;
    logic [SAMPLE_W-1:0] active_reg;
    logic [SAMPLE_W-1:0] active_next;
    logic                audio_reg;
    logic                audio_next;
    logic                capture;
    logic                pwm_wrap;

    audio_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock      (clock),
        .reset      (reset),
        .sample_ena (sample_ena),
        .div_cnt    (div_cnt)
    );

    // The generator updates on the strobe edge, so its output is stable one cycle later.
    assign capture  = (div_cnt == '0);
    assign pwm_wrap = (pwm_cnt_reg == PWM_LAST);

    always_comb begin
        pwm_cnt_next = pwm_cnt_reg + SAMPLE_W'(1);
        if (pwm_wrap) begin
            pwm_cnt_next = '0;
        end
    end

    // Only reload at a period boundary; a same-cycle capture bypasses pending.
    always_comb begin
        active_next = active_reg;
        if (pwm_wrap) begin
            active_next = capture ? sample : pending_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
            pending_reg <= '0;
            active_reg  <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_next;
            active_reg  <= active_next;
            if (capture) begin
                pending_reg <= sample;
            end
        end
    end

`ifdef AUDIO_SDM_EN
    logic [SAMPLE_W-1:0] acc_reg;
    logic [SAMPLE_W:0]   sdm_sum;

    assign sdm_sum = {1'b0, acc_reg} + {1'b0, active_reg};

    always_comb begin
        audio_next = mute ? 1'b0 : sdm_sum[SAMPLE_W];
    end

    always_ff @(posedge clock) begin
        if (reset || mute) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= sdm_sum[SAMPLE_W-1:0];
        end
    end
`else
    always_comb begin
        audio_next = mute ? 1'b0 : (pwm_cnt_reg < active_reg);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            audio_reg <= 1'b0;
        end else begin
            audio_reg <= audio_next;
        end
    end

    assign audio_out     = audio_reg;
    assign active_sample = active_reg;

endmodule

// File: tb/tb_audio_dac_out.sv
// Directed bench for audio_dac_out with CLK_DIV=16, SAMPLE_W=4; cyc counts edges since reset release.
module tb_audio_dac_out;

    localparam int CLK_DIV = 16;
    localparam int SW      = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mute  = 1'b0;
    logic [SW-1:0] sample = '0;
    logic          sample_ena;
    logic          audio_out;
    logic [SW-1:0] active_sample;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    audio_dac_out #(
        .CLK_DIV  (CLK_DIV),
        .SAMPLE_W (SW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sample        (sample),
        .mute          (mute),
        .sample_ena    (sample_ena),
        .audio_out     (audio_out),
        .active_sample (active_sample)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset(input logic [SW-1:0] s);
        sample = s;
        mute   = 1'b0;
        reset  = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        logic exp_ena;
        reset = 1'b1;
        step();
        step();
        checks++;
        if (sample_ena !== 1'b0 || audio_out !== 1'b0 || active_sample !== '0) begin
            failures++;
            $display("FAIL reset_state ena=%b audio=%b active=%0d required 0/0/0",
                     sample_ena, audio_out, active_sample);
        end
        reset = 1'b0;
        cyc   = 0;
        while (cyc <= 50) begin
            exp_ena = ((cyc % CLK_DIV) == CLK_DIV - 1);
            checks++;
            if (sample_ena !== exp_ena) begin
                failures++;
                $display("FAIL strobe_timing cyc=%0d got=%b required=%b", cyc, sample_ena, exp_ena);
            end
            step();
        end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_pwm_duty(input logic [SW-1:0] k);
        int highs;
        do_reset(k);
        run_to(40);
        for (int w = 0; w < 3; w++) begin
            highs = 0;
            for (int i = 0; i < 15; i++) begin
                if (audio_out === 1'b1) highs++;
                step();
            end
            checks++;
            if (highs != int'(k)) begin
                failures++;
                $display("FAIL pwm_duty sample=%0d window=%0d highs=%0d required=%0d", k, w, highs, k);
            end
        end
        $display("test_pwm_duty sample=%0d done", k);
    endtask

    task automatic test_sample_change();
        logic [SW-1:0] exp_active;
        int prev;
        int a;
        logic exp_audio;
        do_reset(4'd3);
        while (cyc <= 75) begin
            if (cyc == 20) sample = 4'd12;
            exp_active = (cyc < 15) ? 4'd0 : ((cyc < 45) ? 4'd3 : 4'd12);
            checks++;
            if (active_sample !== exp_active) begin
                failures++;
                $display("FAIL active_change cyc=%0d got=%0d required=%0d", cyc, active_sample, exp_active);
            end
`ifndef AUDIO_SDM_EN
            if (cyc >= 16) begin
                prev = cyc - 1;
                a = (prev < 45) ? 3 : 12;
                exp_audio = ((prev % 15) < a);
                checks++;
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL pwm_period_duty cyc=%0d got=%b required=%b", cyc, audio_out, exp_audio);
                end
            end
`endif
            step();
        end
        $display("test_sample_change done");
    endtask

    task automatic test_forwarding();
        // Edge 224->225 is both a capture (div 0) and a PWM wrap (pwm 14).
        do_reset(4'd2);
        run_to(220);
        sample = 4'd7;
        run_to(224);
        checks++;
        if (active_sample !== 4'd2) begin
            failures++;
            $display("FAIL forward_before got=%0d required=2", active_sample);
        end
        step();
        checks++;
        if (active_sample !== 4'd7) begin
            failures++;
            $display("FAIL forward_same_cycle got=%0d required=7", active_sample);
        end
        $display("test_forwarding done");
    endtask

`ifndef AUDIO_SDM_EN
    task automatic test_mute();
        logic exp_audio;
        logic exp_ena;
        do_reset(4'd9);
        run_to(40);
        mute = 1'b1;
        while (cyc <= 200) begin
            if (cyc == 140) mute = 1'b0;
            if (cyc >= 41) begin
                exp_audio = (cyc <= 140) ? 1'b0 : (((cyc - 1) % 15) < 9);
                checks++;
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL mute_audio cyc=%0d got=%b required=%b", cyc, audio_out, exp_audio);
                end
            end
            exp_ena = ((cyc % CLK_DIV) == CLK_DIV - 1);
            checks++;
            if (sample_ena !== exp_ena) begin
                failures++;
                $display("FAIL mute_strobe cyc=%0d got=%b required=%b", cyc, sample_ena, exp_ena);
            end
            step();
        end
        $display("test_mute done");
    endtask
`else
    task automatic test_sdm();
        logic exp_audio;
        do_reset(4'd8);
        run_to(16);
        while (cyc <= 47) begin
            exp_audio = (cyc % 2) == 1;
            checks++;
            if (audio_out !== exp_audio) begin
                failures++;
                $display("FAIL sdm_half cyc=%0d got=%b required=%b", cyc, audio_out, exp_audio);
            end
            step();
        end
        run_to(40);
        mute = 1'b1;
        while (cyc <= 46) begin
            if (cyc == 43) mute = 1'b0;
            if (cyc >= 41) begin
                exp_audio = (cyc == 45);
                checks++;
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL sdm_mute_clear cyc=%0d got=%b required=%b", cyc, audio_out, exp_audio);
                end
            end
            step();
        end
        do_reset(4'd1);
        run_to(16);
        while (cyc <= 63) begin
            exp_audio = (cyc % 16) == 15;
            checks++;
            if (audio_out !== exp_audio) begin
                failures++;
                $display("FAIL sdm_sixteenth cyc=%0d got=%b required=%b", cyc, audio_out, exp_audio);
            end
            step();
        end
        $display("test_sdm done");
    endtask
`endif

    task automatic test_reset_mid();
        logic exp_ena;
        do_reset(4'd15);
        run_to(23);
        checks++;
        if (audio_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got=%b required=1", audio_out);
        end
        reset = 1'b1;
        step();
        checks++;
        if (sample_ena !== 1'b0 || audio_out !== 1'b0 || active_sample !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs ena=%b audio=%b active=%0d required 0/0/0",
                     sample_ena, audio_out, active_sample);
        end
        reset = 1'b0;
        cyc   = 0;
        while (cyc <= 20) begin
            exp_ena = (cyc == 15);
            checks++;
            if (sample_ena !== exp_ena) begin
                failures++;
                $display("FAIL reset_mid_strobe cyc=%0d got=%b required=%b", cyc, sample_ena, exp_ena);
            end
            step();
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
`ifdef AUDIO_SDM_EN
        test_sdm();
`else
        test_pwm_duty(4'd5);
        test_pwm_duty(4'd0);
        test_pwm_duty(4'd15);
        test_mute();
`endif
        test_sample_change();
        test_forwarding();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
